cpu_fsm: RTL
============

CPU_FSM -- requirements
Module: cpu_fsm

Interface
REQ-001: clk  input  1  single rising-edge clock for all state.
REQ-002: reset_n  input  1  asynchronous, active-low reset.
REQ-003: s  input  1  start request, sampled only in WAIT.
REQ-004: in  input  16  instruction word, captured when s is accepted.
REQ-005: w  output  1  idle flag, high only in WAIT.
REQ-006: readnum, writenum  output  3 each  register-file read and write indices.
REQ-007: write, loada, loadb, loadc, loads  output  1 each  register-file write enable and pipeline-register load strobes.
REQ-008: asel, bsel, vsel  output  1 each  A-operand zero select, B-operand immediate select (tied 0), writeback select (0 = C, 1 = sximm8).
REQ-009: ALUop, shift  output  2 each  ALU operation and shifter code, from ir[12:11] and ir[4:3].
REQ-010: sximm8  output  16  ir[7:0] sign-extended to 16 bits.
REQ-011: err  output  1  illegal-instruction flag, present only with the macro in REQ-026.

Function
REQ-012: On posedge clk with state==WAIT and s==1, the block SHALL load ir<=in; s SHALL be ignored in every other state.
REQ-013: Fields SHALL decode as opcode=ir[15:13], op=ir[12:11], Rn=ir[10:8], Rd=ir[7:5], Rm=ir[2:0].
REQ-014: Control outputs SHALL be Moore outputs decoded from the state register only; every strobe not listed for a state SHALL be 0.
REQ-015: The states SHALL be WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM, plus TRAP with the macro.
REQ-016: The state sequences SHALL be: WAIT -s-> DECODE always; MOV imm (110,10): DECODE->WR_IMM->WAIT; MOV reg (110,00) and MVN (101,11): DECODE->GET_B->EXEC->WR_REG->WAIT; ADD (101,00) and AND (101,10): DECODE->GET_A->GET_B->EXEC->WR_REG->WAIT; CMP (101,01): DECODE->GET_A->GET_B->EXEC->WAIT.
REQ-017: Outputs per state SHALL be: GET_A readnum=Rn, loada=1; GET_B readnum=Rm, loadb=1; EXEC loadc=1 (except CMP), loads=1 for CMP only, asel=1 for MOV reg/MVN; WR_REG writenum=Rd, vsel=0, write=1; WR_IMM writenum=Rn, vsel=1, write=1.
REQ-018: MOV reg SHALL drive ALUop=00 in EXEC, so that C=0+shift(Rm).
REQ-019: Latency SHALL be counted from the accepting edge to w high: MOV imm 3 cycles, MOV reg/MVN/CMP 4, ADD/AND 5.
REQ-020: write SHALL be asserted for exactly one cycle per writing instruction and never for CMP.
REQ-021: If s is high when the block returns to WAIT, the next instruction SHALL be accepted on that edge, giving back-to-back operation.
REQ-022: Unsupported encodings SHALL be opcode not in {110,101}, or opcode 110 with op in {01,11}; their handling SHALL follow REQ-026.

Reset
REQ-023: When reset_n==0, the block SHALL immediately force state=WAIT and ir=16'h0000 without waiting for a clock edge.
REQ-024: During reset, w SHALL be 1, all strobes 0, readnum=writenum=0, sximm8=0, and err=0.
REQ-025: Reset asserted mid-instruction SHALL abort the instruction, and no write pulse SHALL occur for it.

Configuration
REQ-026: Macro CPU_FSM_ILLEGAL_TRAP_EN SHALL control unsupported-encoding handling.
- Defined: DECODE goes to TRAP; TRAP holds w=0 and err=1, ignores s, and is left only by reset.
- Undefined: DECODE goes to WAIT as a 2-cycle NOP; the err port and the TRAP state SHALL not exist.

Verification
REQ-027: Reset, then s=1, in=16'hD107 (MOV R1,#7) -> next cycle WR_IMM: write=1, writenum=1, vsel=1, sximm8=16'h0007; w=1 three cycles after acceptance.
REQ-028: in=16'hA140 (ADD R2,R1,R0) -> readnum=1+loada, readnum=0+loadb, ALUop=00+loadc, writenum=2+write on successive cycles; w=1 after 5 cycles.
REQ-029: in=16'hA900 (CMP R1,R0) -> EXEC: loads=1, loadc=0; write stays 0 throughout; w=1 after 4 cycles.
REQ-030: in=16'hB868 (MVN R3,R0,LSL#1) -> loada never 1; EXEC: asel=1, ALUop=11, shift=01; WR_REG: writenum=3; done in 4 cycles.
REQ-031: Issue 16'hA140 and drive reset_n=0 mid-EXEC -> w=1 and all strobes 0 before the next edge; no write pulse; s held high with 16'hD107 after release -> accepted on the first edge.
REQ-032: in=16'hE000 -> with the macro: err=1, w=0 persists for 10 cycles with s=1, clears on reset; without: w=1 after 2 cycles and no strobes.

Source files
------------

// File: rtl/cpu_fsm.sv
// Instruction-sequencing controller: captures an instruction word on start and steps
// the datapath strobes through read/execute/writeback. Optional CPU_FSM_ILLEGAL_TRAP_EN traps illegal encodings.
module cpu_fsm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [2:0] {
    WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t      state, state_d;
  logic [15:0] ir, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_movi, is_unary, is_cmp, illegal;

  assign opcode   = ir[15:13];
  assign op       = ir[12:11];
  assign is_movi  = (opcode == 3'b110) && (op == 2'b10);
  assign is_unary = ((opcode == 3'b110) && (op == 2'b00)) || ((opcode == 3'b101) && (op == 2'b11));
  assign is_cmp   = (opcode == 3'b101) && (op == 2'b01);
  assign illegal  = !((opcode == 3'b101) || is_movi || ((opcode == 3'b110) && (op == 2'b00)));

  assign ALUop  = ir[12:11];
  assign shift  = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign bsel   = 1'b0;

  always_comb begin
    state_d = state;
    ir_d    = ir;
    case (state)
      WAIT:
        if (s) begin
          state_d = DECODE;
          ir_d    = in;
        end
      DECODE:
        if (illegal) begin
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          state_d = WAIT;
`endif
        end else if (is_movi) begin
          state_d = WR_IMM;
        end else if (is_unary) begin
          state_d = GET_B;
        end else begin
          state_d = GET_A;
        end
      GET_A:          state_d = GET_B;
      GET_B:          state_d = EXEC;
      EXEC:           state_d = is_cmp ? WAIT : WR_REG;
      WR_REG, WR_IMM: state_d = WAIT;
      default:        state_d = state;
    endcase
  end

  // Field views of the instruction the next state will operate on.
  logic [2:0] rn_d, rd_d, rm_d;
  logic       cmp_d, unary_d;

  assign rn_d    = ir_d[10:8];
  assign rd_d    = ir_d[7:5];
  assign rm_d    = ir_d[2:0];
  assign cmp_d   = (ir_d[15:13] == 3'b101) && (ir_d[12:11] == 2'b01);
  assign unary_d = (ir_d[15:13] == 3'b110) || (ir_d[12:11] == 2'b11);

  // Outputs are registered from the next state so they stay pure Moore functions of state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT;
      ir       <= '0;
      w        <= 1'b1;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      vsel     <= 1'b0;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
      err      <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      ir       <= ir_d;
      w        <= (state_d == WAIT);
      loada    <= (state_d == GET_A);
      loadb    <= (state_d == GET_B);
      readnum  <= (state_d == GET_A) ? rn_d : (state_d == GET_B) ? rm_d : 3'd0;
      loadc    <= (state_d == EXEC) && !cmp_d;
      loads    <= (state_d == EXEC) && cmp_d;
      asel     <= (state_d == EXEC) && unary_d;
      write    <= (state_d == WR_REG) || (state_d == WR_IMM);
      writenum <= (state_d == WR_REG) ? rd_d : (state_d == WR_IMM) ? rn_d : 3'd0;
      vsel     <= (state_d == WR_IMM);
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
      err      <= (state_d == TRAP);
`endif
    end
  end

endmodule
